legv8_exec_adders: RTL and testbench
====================================

Name: legv8_exec_adders

Overview:
- Execute-stage datapath block for the single-cycle LEGv8 CPU.
- Merges the 64-bit ALU, the PC+4 incrementer (Adder1) and the branch-target adder (Adder2).
- Produces the next-PC choice (branch AND zero).
- Results are registered once per clock so the CPU core sees stable values on the following cycle.

Parameters:
- DATA_W, 64, ALU operand/result width
- ADDR_W, 32, PC/address width
- PC_STEP, 4, increment applied by the PC incrementer

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-low reset (0 = reset asserted)
- en  input  1  capture enable for output registers
- a_in  input  64  ALU operand A (register file read port 1)
- b_in  input  64  ALU operand B (register port 2 or sign-extended immediate)
- alu_operation  input  3  ALU opcode
- pc  input  32  current instruction address
- instruction  input  32  current instruction word
- branch  input  1  controller branch request
- result  output  64  registered ALU result
- zero  output  1  registered (result == 0)
- pc_plus4  output  32  registered pc + PC_STEP
- branch_target  output  32  registered branch address
- next_pc  output  32  registered selected next PC
- take_branch  output  1  registered branch AND zero

Behaviour:
- ALU is combinational, 64-bit, two's complement. Opcode map:
  - 000 AND
  - 001 ORR
  - 010 ADD
  - 011 EOR
  - 100 LSL (A << B[5:0])
  - 101 LSR (logical, A >> B[5:0])
  - 110 SUB (A - B)
  - 111 PASS_B (result = B)
- ADD/SUB wrap modulo 2^64; carry-out is discarded.
- Zero is computed on the combinational ALU result before registering.
- Shift amounts 0..63 are legal; the amount uses B[5:0] only.
- Adder1: pc + PC_STEP, modulo 2^32. 0xFFFFFFFC + 4 wraps to 0x00000000.
- Adder2 offset field:
  - If instruction[31:26] == 6'b000101 (B): offset = sign-extend(instruction[25:0]) << 2.
  - Otherwise (CBZ/CBNZ/B.cond format): offset = sign-extend(instruction[23:5]) << 2.
  - branch_target = pc + offset, modulo 2^32.
- Selection: take = branch & zero_comb. next_pc = take ? branch_target : pc_plus4.
- Registers:
  - On posedge clk with en=1, all outputs capture their combinational values. Latency is 1 cycle.
  - With en=0, all outputs hold.
- Reset:
  - reset low asynchronously clears result, pc_plus4, branch_target, next_pc and take_branch to 0, and sets zero to 1 (consistent with result = 0).
  - Outputs stay at reset values while reset is low.
  - The first capture is the first rising edge with reset high and en=1.
  - Reset asserted mid-operation discards any pending value immediately, with no clock needed.
- No X propagation on defined inputs. An unknown opcode cannot occur (3-bit code, fully decoded).

Optional Feature:
- Macro LEGV8_EXEC_FLAGS_EN.
- When defined, adds registered outputs:
  - flag_n (result[63])
  - flag_c (carry-out of ADD, or no-borrow of SUB; 0 for other ops)
  - flag_v (signed overflow of ADD/SUB; 0 otherwise)
- The flag outputs reset to 0 and are captured under en like the other outputs.
- When not defined, these ports and their logic do not exist, and the remaining behaviour is identical.

Test Plan:
- Reset low with random inputs -> all outputs 0 and zero = 1, without a clock edge. Release reset, en=1, a_in=5, b_in=3, op=010 -> after 1 edge result = 8, zero = 0.
- op=110, a_in=b_in=0x1234 -> result 0, zero 1. With branch=1, pc=0x40, instruction=0xB4000040 (CBZ, imm19=2) -> branch_target 0x48, take_branch 1, next_pc 0x48.
- op=000/001/011 with a_in=0xF0F0, b_in=0xFF00 -> 0xF000 / 0xFFF0 / 0x0FF0. op=100, a_in=1, b_in=63 -> 0x8000000000000000. op=101 -> 0 for the same operands; op=111, b_in=7 -> 7.
- instruction=0x17FFFFFF (B, offset -1), pc=0x100, branch=1, zero true -> branch_target 0xFC. With branch=0 -> next_pc 0x104. pc=0xFFFFFFFC -> pc_plus4 0.
- en=0 while inputs change -> outputs hold for 3 cycles. Assert reset between clock edges -> outputs clear immediately.
- With LEGV8_EXEC_FLAGS_EN defined: op=010, a_in=0x7FFF_FFFF_FFFF_FFFF, b_in=1 -> result 0x8000000000000000, flag_v 1, flag_n 1, flag_c 0.

Source files
------------

// File: rtl/legv8_exec_adders_if.sv
// Execute-stage bundle: capture enable, ALU/PC inputs and the registered results.
// Flag outputs exist only when LEGV8_EXEC_FLAGS_EN is defined.
interface legv8_exec_adders_if #(
   parameter int DATA_W = 64,
   parameter int ADDR_W = 32
);
   logic              en;
   logic [DATA_W-1:0] a_in;
   logic [DATA_W-1:0] b_in;
   logic [2:0]        alu_operation;
   logic [ADDR_W-1:0] pc;
   logic [31:0]       instruction;
   logic              branch;

   logic [DATA_W-1:0] result;
   logic              zero;
   logic [ADDR_W-1:0] pc_plus4;
   logic [ADDR_W-1:0] branch_target;
   logic [ADDR_W-1:0] next_pc;
   logic              take_branch;
`ifdef LEGV8_EXEC_FLAGS_EN
   logic              flag_n;
   logic              flag_c;
   logic              flag_v;
`endif

   modport master (
      output en, a_in, b_in, alu_operation, pc, instruction, branch,
`ifdef LEGV8_EXEC_FLAGS_EN
      input  flag_n, flag_c, flag_v,
`endif
      input  result, zero, pc_plus4, branch_target, next_pc, take_branch
   );

   modport slave (
      input  en, a_in, b_in, alu_operation, pc, instruction, branch,
`ifdef LEGV8_EXEC_FLAGS_EN
      output flag_n, flag_c, flag_v,
`endif
      output result, zero, pc_plus4, branch_target, next_pc, take_branch
   );
endinterface

// File: rtl/legv8_exec_adders.sv
// LEGv8 execute stage: 64-bit ALU, PC incrementer, branch-target adder, next-PC select.
// Latency 1 cycle; all outputs hold while en=0. Optional NZCV-style flags via LEGV8_EXEC_FLAGS_EN.
module legv8_exec_adders #(
   parameter int DATA_W  = 64,
   parameter int ADDR_W  = 32,
   parameter int PC_STEP = 4
) (
   input  logic                clk,
   input  logic                reset,
   legv8_exec_adders_if.slave  bus
);
   localparam int SH_W = $clog2(DATA_W);

   logic [DATA_W-1:0] add_res, sub_res;
   logic [DATA_W-1:0] result_d, result_q;
   logic              zero_d, zero_q;
   logic [ADDR_W-1:0] pc_plus4_d, pc_plus4_q;
   logic [ADDR_W-1:0] branch_target_d, branch_target_q;
   logic [ADDR_W-1:0] next_pc_d, next_pc_q;
   logic              take_d, take_q;
   logic [ADDR_W-1:0] offset;

`ifdef LEGV8_EXEC_FLAGS_EN
   // Extra MSB carries the adder carry-out; for SUB it is the no-borrow bit.
   logic [DATA_W:0] sum_w, diff_w;
   logic            flag_c_d, flag_v_d;
   logic            flag_n_q, flag_c_q, flag_v_q;

   assign sum_w   = {1'b0, bus.a_in} + {1'b0, bus.b_in};
   assign diff_w  = {1'b0, bus.a_in} + {1'b0, ~bus.b_in} + (DATA_W+1)'(1);
   assign add_res = sum_w[DATA_W-1:0];
   assign sub_res = diff_w[DATA_W-1:0];
`else
   assign add_res = bus.a_in + bus.b_in;
   assign sub_res = bus.a_in - bus.b_in;
`endif

   always_comb begin
      result_d = '0;
      case (bus.alu_operation)
         3'b000: result_d = bus.a_in & bus.b_in;
         3'b001: result_d = bus.a_in | bus.b_in;
         3'b010: result_d = add_res;
         3'b011: result_d = bus.a_in ^ bus.b_in;
         3'b100: result_d = bus.a_in << bus.b_in[SH_W-1:0];
         3'b101: result_d = bus.a_in >> bus.b_in[SH_W-1:0];
         3'b110: result_d = sub_res;
         3'b111: result_d = bus.b_in;
         default: result_d = '0;
      endcase
   end

   assign zero_d = (result_d == '0);

   // B uses imm26; CBZ/CBNZ/B.cond use imm19 at [23:5]. Both are word offsets.
   always_comb begin
      offset = '0;
      if (bus.instruction[31:26] == 6'b000101)
         offset = {{(ADDR_W-28){bus.instruction[25]}}, bus.instruction[25:0], 2'b00};
      else
         offset = {{(ADDR_W-21){bus.instruction[23]}}, bus.instruction[23:5], 2'b00};
   end

   assign pc_plus4_d      = bus.pc + ADDR_W'(PC_STEP);
   assign branch_target_d = bus.pc + offset;
   assign take_d          = bus.branch & zero_d;
   assign next_pc_d       = take_d ? branch_target_d : pc_plus4_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         result_q        <= '0;
         zero_q          <= 1'b1;
         pc_plus4_q      <= '0;
         branch_target_q <= '0;
         next_pc_q       <= '0;
         take_q          <= 1'b0;
      end else if (bus.en) begin
         result_q        <= result_d;
         zero_q          <= zero_d;
         pc_plus4_q      <= pc_plus4_d;
         branch_target_q <= branch_target_d;
         next_pc_q       <= next_pc_d;
         take_q          <= take_d;
      end
   end

   assign bus.result        = result_q;
   assign bus.zero          = zero_q;
   assign bus.pc_plus4      = pc_plus4_q;
   assign bus.branch_target = branch_target_q;
   assign bus.next_pc       = next_pc_q;
   assign bus.take_branch   = take_q;

`ifdef LEGV8_EXEC_FLAGS_EN
   always_comb begin
      flag_c_d = 1'b0;
      flag_v_d = 1'b0;
      if (bus.alu_operation == 3'b010) begin
         flag_c_d = sum_w[DATA_W];
         flag_v_d = (bus.a_in[DATA_W-1] == bus.b_in[DATA_W-1]) &&
                    (sum_w[DATA_W-1] != bus.a_in[DATA_W-1]);
      end else if (bus.alu_operation == 3'b110) begin
         flag_c_d = diff_w[DATA_W];
         flag_v_d = (bus.a_in[DATA_W-1] != bus.b_in[DATA_W-1]) &&
                    (diff_w[DATA_W-1] != bus.a_in[DATA_W-1]);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         flag_n_q <= 1'b0;
         flag_c_q <= 1'b0;
         flag_v_q <= 1'b0;
      end else if (bus.en) begin
         flag_n_q <= result_d[DATA_W-1];
         flag_c_q <= flag_c_d;
         flag_v_q <= flag_v_d;
      end
   end

   assign bus.flag_n = flag_n_q;
   assign bus.flag_c = flag_c_q;
   assign bus.flag_v = flag_v_q;
`endif

endmodule

// File: tb/tb_legv8_exec_adders.sv
// Directed bench for legv8_exec_adders: hand-computed vectors checked on the falling edge.
// Flag checks are compiled in when LEGV8_EXEC_FLAGS_EN is defined.
module tb_legv8_exec_adders;
   logic clk;
   logic reset;
   int   errors = 0;
   int   checks = 0;

   legv8_exec_adders_if #(.DATA_W(64), .ADDR_W(32)) bus ();

   legv8_exec_adders #(.DATA_W(64), .ADDR_W(32), .PC_STEP(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [31:0] pc, input logic [31:0] instr, input logic br);
      bus.alu_operation = op;
      bus.a_in          = a;
      bus.b_in          = b;
      bus.pc            = pc;
      bus.instruction   = instr;
      bus.branch        = br;
   endtask

   initial begin
      reset  = 1'b1;
      bus.en = 1'b1;
      drive(3'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, $urandom, $urandom, 1'b1);
      #1 reset = 1'b0;
      #1;
      chk("rst_result", bus.result, 64'h0);
      chk("rst_zero", {63'b0, bus.zero}, 64'h1);
      chk("rst_pc_plus4", {32'b0, bus.pc_plus4}, 64'h0);
      chk("rst_branch_target", {32'b0, bus.branch_target}, 64'h0);
      chk("rst_next_pc", {32'b0, bus.next_pc}, 64'h0);
      chk("rst_take", {63'b0, bus.take_branch}, 64'h0);
`ifdef LEGV8_EXEC_FLAGS_EN
      chk("rst_flags", {61'b0, bus.flag_n, bus.flag_c, bus.flag_v}, 64'h0);
`endif
      @(posedge clk);
      #1;
      chk("rst_hold_result", bus.result, 64'h0);
      chk("rst_hold_zero", {63'b0, bus.zero}, 64'h1);

      // First capture: ADD 5+3
      @(negedge clk);
      reset = 1'b1;
      drive(3'b010, 64'd5, 64'd3, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("add_result", bus.result, 64'd8);
      chk("add_zero", {63'b0, bus.zero}, 64'h0);
      chk("add_pc_plus4", {32'b0, bus.pc_plus4}, 64'h4);

      // SUB equal operands with CBZ imm19=2
      drive(3'b110, 64'h1234, 64'h1234, 32'h40, 32'hB400_0040, 1'b1);
      @(negedge clk);
      chk("sub_eq_result", bus.result, 64'h0);
      chk("sub_eq_zero", {63'b0, bus.zero}, 64'h1);
      chk("cbz_target", {32'b0, bus.branch_target}, 64'h48);
      chk("cbz_take", {63'b0, bus.take_branch}, 64'h1);
      chk("cbz_next_pc", {32'b0, bus.next_pc}, 64'h48);
      chk("cbz_pc_plus4", {32'b0, bus.pc_plus4}, 64'h44);
`ifdef LEGV8_EXEC_FLAGS_EN
      chk("sub_eq_flags", {61'b0, bus.flag_n, bus.flag_c, bus.flag_v}, 64'h2);
`endif

      drive(3'b110, 64'd3, 64'd5, 32'h40, 32'hB400_0040, 1'b1);
      @(negedge clk);
      chk("sub_neg_result", bus.result, 64'hFFFF_FFFF_FFFF_FFFE);
      chk("sub_neg_take", {63'b0, bus.take_branch}, 64'h0);
      chk("sub_neg_next_pc", {32'b0, bus.next_pc}, 64'h44);

      drive(3'b000, 64'hF0F0, 64'hFF00, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("and_result", bus.result, 64'hF000);
      drive(3'b001, 64'hF0F0, 64'hFF00, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("orr_result", bus.result, 64'hFFF0);
      drive(3'b011, 64'hF0F0, 64'hFF00, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("eor_result", bus.result, 64'h0FF0);

      drive(3'b100, 64'd1, 64'd63, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("lsl63_result", bus.result, 64'h8000_0000_0000_0000);
      drive(3'b100, 64'd1, 64'h0000_0000_0000_0141, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("lsl_b5_0_only", bus.result, 64'h2);
      drive(3'b101, 64'd1, 64'd63, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("lsr63_result", bus.result, 64'h0);
      chk("lsr63_zero", {63'b0, bus.zero}, 64'h1);
      drive(3'b101, 64'h8000_0000_0000_0000, 64'd4, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("lsr_logical", bus.result, 64'h0800_0000_0000_0000);
      drive(3'b111, 64'd99, 64'd7, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("passb_result", bus.result, 64'd7);

      // Unconditional B with offset -1 word, zero true
      drive(3'b110, 64'd9, 64'd9, 32'h100, 32'h17FF_FFFF, 1'b1);
      @(negedge clk);
      chk("b_target", {32'b0, bus.branch_target}, 64'hFC);
      chk("b_take", {63'b0, bus.take_branch}, 64'h1);
      chk("b_next_pc", {32'b0, bus.next_pc}, 64'hFC);
      drive(3'b110, 64'd9, 64'd9, 32'h100, 32'h17FF_FFFF, 1'b0);
      @(negedge clk);
      chk("nobr_take", {63'b0, bus.take_branch}, 64'h0);
      chk("nobr_next_pc", {32'b0, bus.next_pc}, 64'h104);

      drive(3'b010, 64'd5, 64'd3, 32'hFFFF_FFFC, 32'h17FF_FFFF, 1'b0);
      @(negedge clk);
      chk("wrap_pc_plus4", {32'b0, bus.pc_plus4}, 64'h0);
      chk("wrap_target", {32'b0, bus.branch_target}, 64'hFFFF_FFF8);
      chk("wrap_result", bus.result, 64'd8);

      // Hold with en low while inputs move
      bus.en = 1'b0;
      for (int i = 0; i < 3; i++) begin
         drive(3'b110, 64'd7, 64'd7, 32'h200 + 32'(i), 32'hB400_0040, 1'b1);
         @(negedge clk);
         chk("hold_result", bus.result, 64'd8);
         chk("hold_zero", {63'b0, bus.zero}, 64'h0);
         chk("hold_target", {32'b0, bus.branch_target}, 64'hFFFF_FFF8);
      end

      // Reset between edges clears without a clock
      #2 reset = 1'b0;
      #1;
      chk("midrst_result", bus.result, 64'h0);
      chk("midrst_zero", {63'b0, bus.zero}, 64'h1);
      chk("midrst_target", {32'b0, bus.branch_target}, 64'h0);
      chk("midrst_next_pc", {32'b0, bus.next_pc}, 64'h0);

`ifdef LEGV8_EXEC_FLAGS_EN
      @(negedge clk);
      reset  = 1'b1;
      bus.en = 1'b1;
      drive(3'b010, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("ovf_result", bus.result, 64'h8000_0000_0000_0000);
      chk("ovf_flag_v", {63'b0, bus.flag_v}, 64'h1);
      chk("ovf_flag_n", {63'b0, bus.flag_n}, 64'h1);
      chk("ovf_flag_c", {63'b0, bus.flag_c}, 64'h0);
      drive(3'b010, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("carry_flags", {61'b0, bus.flag_n, bus.flag_c, bus.flag_v}, 64'h2);
      drive(3'b000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 32'h0, 32'h0, 1'b0);
      @(negedge clk);
      chk("logic_flags", {61'b0, bus.flag_n, bus.flag_c, bus.flag_v}, 64'h4);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
